// File: rtl/em_pipe.sv
// EX->MEM pipeline register: one flop stage for control, destination index and data.
// Optional stall/flush controls are enabled with `define EMPIPE_STALL_FLUSH_EN.
module em_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
`ifdef EMPIPE_STALL_FLUSH_EN
  input  logic              stall_M,
  input  logic              flush_E,
`endif
  input  logic              regw_E,
  input  logic              memw_E,
  input  logic              regmem_E,
  input  logic [REG_W-1:0]  regScr_E,
  input  logic [DATA_W-1:0] ALUrslt_E,
  input  logic [DATA_W-1:0] address_E,
  output logic              regw_M,
  output logic              memw_M,
  output logic              regmem_M,
  output logic [REG_W-1:0]  regScr_M,
  output logic [DATA_W-1:0] ALUrslt_M,
  output logic [DATA_W-1:0] address_M
);

  logic              r_regw;
  logic              r_memw;
  logic              r_regmem;
  logic [REG_W-1:0]  r_regScr;
  logic [DATA_W-1:0] r_ALUrslt;
  logic [DATA_W-1:0] r_address;

  // All fields share one stage so control and data can never skew.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_regw    <= 1'b0;
      r_memw    <= 1'b0;
      r_regmem  <= 1'b0;
      r_regScr  <= '0;
      r_ALUrslt <= '0;
      r_address <= '0;
    end
`ifdef EMPIPE_STALL_FLUSH_EN
    else if (flush_E) begin
      r_regw    <= 1'b0;
      r_memw    <= 1'b0;
      r_regmem  <= 1'b0;
      r_regScr  <= '0;
      r_ALUrslt <= '0;
      r_address <= '0;
    end else if (!stall_M) begin
`else
    else begin
`endif
      r_regw    <= regw_E;
      r_memw    <= memw_E;
      r_regmem  <= regmem_E;
      r_regScr  <= regScr_E;
      r_ALUrslt <= ALUrslt_E;
      r_address <= address_E;
    end
  end

  assign regw_M    = r_regw;
  assign memw_M    = r_memw;
  assign regmem_M  = r_regmem;
  assign regScr_M  = r_regScr;
  assign ALUrslt_M = r_ALUrslt;
  assign address_M = r_address;

endmodule

// File: tb/tb_em_pipe.sv
// Directed self-checking bench for em_pipe; stall/flush steps run when
// EMPIPE_STALL_FLUSH_EN is defined.
module tb_em_pipe;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned VEC_W  = 3 + REG_W + 2 * DATA_W;

  logic              clk;
  logic              rst;
  logic              stall_M;
  logic              flush_E;
  logic              regw_E, memw_E, regmem_E;
  logic [REG_W-1:0]  regScr_E;
  logic [DATA_W-1:0] ALUrslt_E, address_E;
  logic              regw_M, memw_M, regmem_M;
  logic [REG_W-1:0]  regScr_M;
  logic [DATA_W-1:0] ALUrslt_M, address_M;

  logic [VEC_W-1:0]  obs;
  logic [VEC_W-1:0]  zero_v, va, vb, vglitch, vc, vd, ve, vf, vg;
  int                n_chk;
  int                n_pass;

  em_pipe #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef EMPIPE_STALL_FLUSH_EN
    .stall_M   (stall_M),
    .flush_E   (flush_E),
`endif
    .regw_E    (regw_E),
    .memw_E    (memw_E),
    .regmem_E  (regmem_E),
    .regScr_E  (regScr_E),
    .ALUrslt_E (ALUrslt_E),
    .address_E (address_E),
    .regw_M    (regw_M),
    .memw_M    (memw_M),
    .regmem_M  (regmem_M),
    .regScr_M  (regScr_M),
    .ALUrslt_M (ALUrslt_M),
    .address_M (address_M)
  );

  assign obs = {regw_M, memw_M, regmem_M, regScr_M, ALUrslt_M, address_M};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [VEC_W-1:0] vec(input logic rw, input logic mw, input logic rm,
                                           input logic [REG_W-1:0] rs,
                                           input logic [DATA_W-1:0] alu,
                                           input logic [DATA_W-1:0] addr);
    return {rw, mw, rm, rs, alu, addr};
  endfunction

  task automatic drive(input logic [VEC_W-1:0] v);
    {regw_E, memw_E, regmem_E, regScr_E, ALUrslt_E, address_E} = v;
  endtask

  task automatic chk(input string tag, input logic [VEC_W-1:0] e);
    n_chk++;
    assert (obs === e) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, e);
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    stall_M = 1'b0;
    flush_E = 1'b0;
    rst     = 1'b0;
    zero_v  = '0;
    va      = vec(1'b1, 1'b0, 1'b0, 4'h3, 32'h0000FFFF, 32'h00010004);
    vb      = vec(1'b1, 1'b0, 1'b0, 4'h4, 32'h0000FFFF, 32'h00000000);
    vglitch = vec(1'b0, 1'b1, 1'b1, 4'hB, 32'hA5A5A5A5, 32'h5A5A5A5A);
    vc      = vec(1'b0, 1'b1, 1'b1, 4'hF, 32'h80000001, 32'hDEADBEEF);
    vd      = vec(1'b1, 1'b1, 1'b0, 4'hA, 32'h7FFFFFFE, 32'h00000010);
    ve      = vec(1'b1, 1'b0, 1'b1, 4'h7, 32'h12345678, 32'h9ABCDEF0);
    vf      = vec(1'b0, 1'b0, 1'b1, 4'h1, 32'hCAFEF00D, 32'h00000FFC);
    vg      = vec(1'b1, 1'b1, 1'b1, 4'hE, 32'h00000001, 32'hFFFFFFFF);

    // Reset with every input high, checked before the first clock edge.
    drive(vec(1'b1, 1'b1, 1'b1, 4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF));
    #1 rst = 1'b1;
    #1 chk("reset_before_edge", zero_v);
    @(posedge clk); #1 chk("reset_edge1", zero_v);
    @(posedge clk); #1 chk("reset_edge2", zero_v);

    // Single capture; nothing moves before the edge.
    @(negedge clk);
    rst = 1'b0;
    drive(va);
    #1 chk("no_capture_before_edge", zero_v);
    @(posedge clk); #1 chk("single_capture", va);

    // Back-to-back; previous value visible until the next edge.
    @(negedge clk);
    drive(vb);
    #1 chk("prev_still_visible", va);
    @(posedge clk); #1 chk("back_to_back", vb);

    // Mid-cycle glitch restored before the edge.
    @(negedge clk);
    drive(vglitch);
    #1 chk("glitch_no_effect", vb);
    #1 drive(vb);
    @(posedge clk); #1 chk("glitch_restored", vb);

    // Full-width patterns and the other control bits.
    @(negedge clk);
    drive(vc);
    @(posedge clk); #1 chk("pattern_c", vc);
    @(negedge clk);
    drive(vd);
    @(posedge clk); #1 chk("pattern_d", vd);

    // Async reset between edges, then capture on first edge after release.
    @(negedge clk);
    #1 rst = 1'b1;
    #1 chk("async_reset_mid", zero_v);
    drive(ve);
    @(posedge clk); #1 chk("reset_holds_over_edge", zero_v);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("zero_until_edge", zero_v);
    @(posedge clk); #1 chk("capture_after_release", ve);

`ifdef EMPIPE_STALL_FLUSH_EN
    @(negedge clk);
    stall_M = 1'b1;
    drive(vf);
    @(posedge clk); #1 chk("stall_hold", ve);
    @(negedge clk);
    stall_M = 1'b0;
    @(posedge clk); #1 chk("stall_release", vf);
    @(negedge clk);
    stall_M = 1'b1;
    flush_E = 1'b1;
    drive(vg);
    @(posedge clk); #1 chk("flush_over_stall", zero_v);
    @(negedge clk);
    stall_M = 1'b0;
    flush_E = 1'b0;
    @(posedge clk); #1 chk("after_flush", vg);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/em_pipe.md
Name:
em_pipe

Overview:
- EX→MEM pipeline register of the pipelined processor.
- Captures the Execute-stage control bits (register write, memory write, register-from-memory select), the destination register index, the ALU result and the memory address/store data on each rising clock edge.
- Presents these values to the Memory stage one cycle later.
- Pure storage with no combinational transformation of data.

Parameters:
- DATA_W, 32, width of ALUrslt and address buses
- REG_W, 4, width of regScr (destination register index; 16 architectural registers)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- regw_E  input  1  EX-stage register-file write enable
- memw_E  input  1  EX-stage data-memory write enable
- regmem_E  input  1  EX-stage writeback select (1 = memory data, 0 = ALU result)
- regScr_E  input  REG_W  EX-stage destination register index
- ALUrslt_E  input  DATA_W  EX-stage ALU result
- address_E  input  DATA_W  EX-stage memory address / store-data word
- regw_M  output  1  registered regw_E
- memw_M  output  1  registered memw_E
- regmem_M  output  1  registered regmem_E
- regScr_M  output  REG_W  registered regScr_E
- ALUrslt_M  output  DATA_W  registered ALUrslt_E
- address_M  output  DATA_W  registered address_E

Behaviour:
- Single clock domain (clk). Reset is asynchronous and active-high (rst); it is fixed in polarity and synchronicity.
- Reset:
  - While rst=1, all outputs are 0 immediately, without waiting for a clock edge.
  - Outputs stay 0 until the first rising clk edge after rst deasserts.
  - Reset asserted mid-operation discards the in-flight stage contents.
- Normal operation (rst=0):
  - On every rising clk edge, each _M output takes the value of its _E input sampled at that edge.
  - Latency is exactly 1 cycle; throughput is 1 transfer per cycle.
  - There is no handshake and no hold in the base configuration.
- Outputs are driven directly from flops, with no combinational path from any input to any output.
- Widths pass through unchanged: no truncation, no sign or zero extension.
- Input changes between edges have no effect until the next rising edge.
- rst left unconnected or tied low means normal operation. Before any edge, outputs are X in simulation; this is acceptable because no reset was applied.
- All fields share one register stage, so control, register index and data always stay aligned.

Optional Feature:
- Macro: EMPIPE_STALL_FLUSH_EN.
- When defined, two extra 1-bit inputs are added after rst:
  - stall_M: while 1, all outputs hold their current value at the clock edge.
  - flush_E: when 1 at a clock edge, the stage loads a bubble: all outputs become 0.
- Priority: rst > flush_E > stall_M > normal capture.
- When not defined:
  - The ports do not exist.
  - The block behaves exactly as a plain register as described above.

Test Plan:
- Reset: drive rst=1 with all inputs non-zero (regScr_E=4'hF, ALUrslt_E=32'hFFFFFFFF) -> all outputs 0 immediately, before any clk edge; they remain 0 while rst=1 across edges.
- Single capture: rst=0; drive regw_E=1, memw_E=0, regmem_E=0, regScr_E=4'b0011, ALUrslt_E=32'h0000FFFF, address_E=32'h00010004 -> after the next rising edge, regw_M=1, memw_M=0, regmem_M=0, regScr_M=3, ALUrslt_M=32'h0000FFFF, address_M=32'h00010004. Outputs must not change before that edge.
- Back-to-back: one cycle later, drive regScr_E=4'b0100, ALUrslt_E=32'h0000FFFF, address_E=32'h00000000 -> next edge gives regScr_M=4, address_M=0, regw_M=1. The previous value must be visible for exactly one cycle.
- Mid-cycle glitch: change inputs between edges and restore them before the edge -> outputs unchanged.
- Async reset mid-operation: with outputs non-zero, assert rst between clock edges -> outputs 0 within the same time step. Deassert rst -> the first rising edge captures the current inputs.
- With EMPIPE_STALL_FLUSH_EN:
  - stall_M=1 with new inputs -> outputs hold the prior values.
  - flush_E=1 together with stall_M=1 -> all outputs 0 after the edge.
